// File: rtl/sys_arr_sched_pkg.sv
// Shared types and default parameter values for the sysArr scheduler.
package sys_arr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned CYC_W_DEF   = 16;

endpackage

// File: rtl/sys_arr_sched_if.sv
// Requester and sysArr handshake bundle shared by the scheduler and its environment.
interface sys_arr_sched_if
    import sys_arr_sched_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned SEL_W = $clog2(N_REQ)
);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] done;
    logic [SEL_W-1:0] sel;
    logic             sa_start;
    logic             sa_ack;
    logic             sa_rdy;
    logic             sa_valid;

    modport master (
        input  req, sa_rdy, sa_valid,
        output gnt, sel, done, sa_start, sa_ack
    );

    modport slave (
        output req, sa_rdy, sa_valid,
        input  gnt, sel, done, sa_start, sa_ack
    );

endinterface

// File: rtl/sys_arr_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned SEL_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [2*N_REQ-1:0] dbl;
    logic [2*N_REQ-1:0] masked;
    logic [SEL_W:0]     pos;
    logic               found;

    // Duplicate the request vector, mask below rr_ptr, take the lowest surviving bit.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            masked[i] = dbl[i] && (i >= 32'(rr_ptr));
        end
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                pos   = (SEL_W+1)'(i);
            end
        end
        if (pos >= (SEL_W+1)'(N_REQ)) begin
            idx = SEL_W'(pos - (SEL_W+1)'(N_REQ));
        end else begin
            idx = SEL_W'(pos);
        end
        any    = |req;
        onehot = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/sys_arr_sched.sv
// Round-robin scheduler sharing one sysArr among N_REQ requesters, with job
// latency capture and a sticky watchdog flag.
module sys_arr_sched
    import sys_arr_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEF,
    parameter int unsigned SEL_W   = $clog2(N_REQ),
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CYC_W   = CYC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sys_arr_sched_if.master   bus,
    output logic              busy,
    output logic [CYC_W-1:0]  job_cycles,
    output logic              timeout_err
);

    sched_state_t     state;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] next_ptr;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] done_q;
    logic             start_q;
    logic             ack_q;
    logic [CYC_W-1:0] cnt;
    logic [CYC_W-1:0] cnt_next;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Saturating cycle counter increment and round-robin pointer advance past the winner.
    always_comb begin
        cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
        next_ptr = (sel_q == SEL_W'(N_REQ - 1)) ? '0 : sel_q + 1'b1;
    end

    // Scheduler FSM; every handshake output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            start_q     <= 1'b0;
            ack_q       <= 1'b0;
            cnt         <= '0;
            job_cycles  <= '0;
            timeout_err <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_any && bus.sa_rdy) begin
                        sel_q   <= pick_idx;
                        gnt_q   <= pick_onehot;
                        start_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    cnt     <= CYC_W'(1);
                    state   <= BUSY;
                end
                BUSY: begin
                    cnt <= cnt_next;
                    if (32'(cnt_next) >= TIMEOUT) begin
                        timeout_err <= 1'b1;
                    end
                    // Done/latency/pointer are registered here so they appear on the first RESP cycle.
                    if (bus.sa_valid) begin
                        state      <= RESP;
                        ack_q      <= 1'b1;
                        done_q     <= gnt_q;
                        job_cycles <= cnt_next;
                        rr_ptr     <= next_ptr;
                    end
                end
                RESP: begin
                    if (!bus.sa_valid) begin
                        gnt_q <= '0;
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.done     = done_q;
    assign bus.sa_start = start_q;
    assign bus.sa_ack   = ack_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sys_arr_sched.sv
// Directed bench for sys_arr_sched with a behavioural sysArr model
// (valid rises 20 cycles after start, held until acked past its first cycle).
module tb_sys_arr_sched;

    localparam int LAT = 20;
    localparam logic [1:0] M_IDLE   = 2'd0;
    localparam logic [1:0] M_BUSY   = 2'd1;
    localparam logic [1:0] M_VALID1 = 2'd2;
    localparam logic [1:0] M_DONE   = 2'd3;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
    } job_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic [15:0] job_cycles;
    logic        timeout_err;

    logic        force_valid;
    logic        block_rdy;
    logic        never_valid;
    logic [1:0]  m_state;
    int          m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sys_arr_sched_if #(.N_REQ(4)) bus ();

    sys_arr_sched #(
        .N_REQ   (4),
        .TIMEOUT (64),
        .CYC_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .job_cycles  (job_cycles),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // sysArr model: ignores ack on its first valid cycle, then waits for ack.
    always @(posedge clk) begin
        if (!rst) begin
            m_state <= M_IDLE;
            m_cnt   <= 0;
        end else begin
            case (m_state)
                M_IDLE:   if (bus.sa_start) begin m_state <= M_BUSY; m_cnt <= 1; end
                M_BUSY: begin
                    m_cnt <= m_cnt + 1;
                    if (!never_valid && m_cnt == LAT - 1) m_state <= M_VALID1;
                end
                M_VALID1: m_state <= M_DONE;
                default:  if (bus.sa_ack) m_state <= M_IDLE;
            endcase
        end
    end

    assign bus.sa_rdy   = (m_state == M_IDLE) && !block_rdy;
    assign bus.sa_valid = (m_state == M_VALID1) || (m_state == M_DONE) || force_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic string nm(input int id, input string s);
        return $sformatf("job%0d_%s", id, s);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 32'h0);
        check({tag, "_sel"},   32'(bus.sel), 32'h0);
        check({tag, "_done"},  32'(bus.done), 32'h0);
        check({tag, "_start"}, 32'(bus.sa_start), 32'h0);
        check({tag, "_ack"},   32'(bus.sa_ack), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_jobc"},  32'(job_cycles), 32'h0);
        check({tag, "_tmo"},   32'(timeout_err), 32'h0);
    endtask

    task automatic wait_grant(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Full job: grant, start pulse, one done with latency 21, ack >= 2 cycles, back to idle.
    task automatic run_job(input int id, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es);
        bit seen;
        int n, dones, acks, starts, done_at;
        @(negedge clk);
        bus.req = r;
        wait_grant(seen);
        check(nm(id, "grant_seen"), 32'(seen), 32'h1);
        if (!seen) begin
            bus.req = '0;
            return;
        end
        check(nm(id, "gnt"),   32'(bus.gnt), 32'(eg));
        check(nm(id, "sel"),   32'(bus.sel), 32'(es));
        check(nm(id, "start"), 32'(bus.sa_start), 32'h1);
        check(nm(id, "busy"),  32'(busy), 32'h1);
        @(negedge clk);
        check(nm(id, "start_pulse"), 32'(bus.sa_start), 32'h0);
        dones = 0; acks = 0; starts = 0; done_at = -1; n = 0;
        while (busy && n < 200) begin
            if (bus.done != '0) begin
                dones++;
                done_at = n;
                check(nm(id, "done"), 32'(bus.done), 32'(eg));
                check(nm(id, "job_cycles"), 32'(job_cycles), 32'd21);
                bus.req = '0;
            end
            if (bus.sa_ack) acks++;
            if (bus.sa_start) starts++;
            @(negedge clk);
            n++;
        end
        check(nm(id, "job_end"),    32'(busy), 32'h0);
        check(nm(id, "done_count"), 32'(dones), 32'd1);
        check(nm(id, "done_time"),  32'(done_at), 32'd20);
        check(nm(id, "ack_ge2"),    32'(acks >= 2), 32'h1);
        check(nm(id, "no_restart"), 32'(starts), 32'd0);
        check(nm(id, "gnt_clear"),  32'(bus.gnt), 32'h0);
        bus.req = '0;
    endtask

    job_vec_t vecs[15];

    initial begin
        bit seen;
        vecs[0]  = '{4'b0100, 4'b0100, 2'd2};
        vecs[1]  = '{4'b1000, 4'b1000, 2'd3};
        vecs[2]  = '{4'hF,    4'b0001, 2'd0};
        vecs[3]  = '{4'hF,    4'b0010, 2'd1};
        vecs[4]  = '{4'hF,    4'b0100, 2'd2};
        vecs[5]  = '{4'hF,    4'b1000, 2'd3};
        vecs[6]  = '{4'hF,    4'b0001, 2'd0};
        vecs[7]  = '{4'hF,    4'b0010, 2'd1};
        vecs[8]  = '{4'hF,    4'b0100, 2'd2};
        vecs[9]  = '{4'hF,    4'b1000, 2'd3};
        vecs[10] = '{4'b0110, 4'b0010, 2'd1};
        vecs[11] = '{4'b0011, 4'b0001, 2'd0};
        vecs[12] = '{4'b0001, 4'b0001, 2'd0};
        vecs[13] = '{4'b1001, 4'b1000, 2'd3};
        vecs[14] = '{4'b1100, 4'b0100, 2'd2};

        rst = 1'b0; bus.req = 4'hF;
        force_valid = 1'b0; block_rdy = 1'b0; never_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        bus.req = '0;
        rst = 1'b1;

        // Spurious valid while idle must not produce ack or done.
        force_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("spur_ack",  32'(bus.sa_ack), 32'h0);
            check("spur_done", 32'(bus.done), 32'h0);
            check("spur_busy", 32'(busy), 32'h0);
        end
        force_valid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_job(i, vecs[i].req, vecs[i].gnt, vecs[i].sel);
        end

        // Watchdog: valid never arrives; rr_ptr is 3 here, so req 0001 wins.
        never_valid = 1'b1;
        @(negedge clk);
        bus.req = 4'b0001;
        wait_grant(seen);
        check("wd_grant_seen", 32'(seen), 32'h1);
        check("wd_gnt", 32'(bus.gnt), 32'h1);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 63) check("wd_tmo_early", 32'(timeout_err), 32'h0);
            if (k == 64) begin
                check("wd_tmo_set", 32'(timeout_err), 32'h1);
                check("wd_busy",    32'(busy), 32'h1);
            end
        end
        check("wd_sticky", 32'(timeout_err), 32'h1);
        check("wd_still_busy", 32'(busy), 32'h1);
        check("wd_no_done", 32'(bus.done), 32'h0);
        rst = 1'b0; bus.req = '0;
        @(negedge clk);
        check_reset_outputs("wd_reset");
        rst = 1'b1; never_valid = 1'b0;

        // sysArr not ready: no grant while blocked.
        block_rdy = 1'b1;
        bus.req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("nordy_gnt",  32'(bus.gnt), 32'h0);
            check("nordy_busy", 32'(busy), 32'h0);
        end
        bus.req = '0;
        block_rdy = 1'b0;
        run_job(100, 4'b0001, 4'b0001, 2'd0);

        // Reset mid-BUSY with rr_ptr=1; req 0011 afterwards tells a cleared pointer (bit 0) from a stale one (bit 1).
        @(negedge clk);
        bus.req = 4'b0100;
        wait_grant(seen);
        check("mid_grant_seen", 32'(seen), 32'h1);
        check("mid_gnt", 32'(bus.gnt), 32'h4);
        check("mid_sel", 32'(bus.sel), 32'h2);
        repeat (10) @(negedge clk);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b0; bus.req = '0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b1;
        run_job(101, 4'b0011, 4'b0001, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1);
    end

endmodule
